// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_pkg
// Purpose  : Shared constants, divisor word type and half-period helper for
//            the multi-channel clock divider.
// Revision : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    localparam int DIV_MIN          = 2;
    localparam int CNT_W_DEFAULT    = 16;
    localparam int DIV_DEFAULT_1MHZ = 100;

    typedef logic [CNT_W_DEFAULT-1:0] div_word_t;

    // Number of low cycles in a period of n; odd n puts the extra cycle high.
    function automatic div_word_t half_period(input div_word_t n);
        return n >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_channel
// Purpose  : One divider channel: counter, active/pending divisor, registered
//            clock level and rising-edge tick.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(DIV_DEFAULT_1MHZ)
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             i_enable,
    input  logic             i_sync,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    output logic             o_pending,
    output logic             o_clk,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] c_DIV_MIN = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;

    logic [CNT_W-1:0] w_load_div;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_div_next;
    logic [CNT_W-1:0] w_half_next;
    logic             w_wrap;
    logic             w_apply;

    always_comb begin
        w_load_div  = (i_load_value < c_DIV_MIN) ? c_DIV_MIN : i_load_value;
        w_wrap      = (r_cnt == (r_div - c_ONE));
        w_apply     = i_sync || (i_enable && w_wrap);
        w_cnt_next  = r_cnt;
        w_div_next  = r_div;
        if (w_apply) begin
            w_cnt_next = '0;
            if (r_pend) begin
                w_div_next = r_pend_div;
            end
        end else if (i_enable) begin
            w_cnt_next = r_cnt + c_ONE;
        end
        w_half_next = CNT_W'(half_period(div_word_t'(w_div_next)));
    end

    // Output level and tick are decoded from the next count so they line up
    // with the count they describe once registered.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_div      <= DIV_DEFAULT;
            r_pend_div <= DIV_DEFAULT;
            r_pend     <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_div <= w_div_next;
            if (w_apply) begin
                r_pend <= 1'b0;
            end
            if (i_load) begin
                r_pend     <= 1'b1;
                r_pend_div <= w_load_div;
            end
            if (i_sync) begin
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else if (i_enable) begin
                r_clk  <= (w_cnt_next >= w_half_next);
                r_tick <= (w_cnt_next == w_half_next);
            end else begin
                r_tick <= 1'b0;
            end
        end
    end

    assign o_pending = r_pend;
    assign o_clk     = r_clk;
    assign o_tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_multi
// Purpose  : NUM_CH programmable clock dividers with glitch-free divisor
//            reload; define CLKDIV_PHASE_ALIGN_EN to add the phase_sync input.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int NUM_CH      = 2,
    parameter int DIV_DEFAULT = DIV_DEFAULT_1MHZ
) (
    input  logic              clk_in,
    input  logic              reset_n,
`ifdef CLKDIV_PHASE_ALIGN_EN
    input  logic              phase_sync,
`endif
    input  logic              enable,
    input  logic              div_load,
    input  logic [2:0]        div_ch,
    input  logic [CNT_W-1:0]  div_value,
    output logic [NUM_CH-1:0] div_pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic w_sync;

`ifdef CLKDIV_PHASE_ALIGN_EN
    assign w_sync = phase_sync;
`else
    assign w_sync = 1'b0;
`endif

    // Full 3-bit compare, so an out-of-range channel index matches nobody.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_load;
        assign w_load = div_load && (div_ch == 3'(g));

        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (CNT_W'(DIV_DEFAULT))
        ) u_channel (
            .clk_in       (clk_in),
            .reset_n      (reset_n),
            .i_enable     (enable),
            .i_sync       (w_sync),
            .i_load       (w_load),
            .i_load_value (div_value),
            .o_pending    (div_pending[g]),
            .o_clk        (clk_out[g]),
            .o_tick       (tick[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_multi
// Purpose  : Scoreboard bench: expected tick cycles are queued per channel and
//            a monitor pops them as ticks appear; level/pending spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_multi;

    localparam int CNT_W  = 16;
    localparam int NUM_CH = 2;

    logic              clk_in     = 1'b0;
    logic              reset_n    = 1'b0;
    logic              enable     = 1'b1;
    logic              div_load   = 1'b0;
    logic [2:0]        div_ch     = 3'd0;
    logic [CNT_W-1:0]  div_value  = '0;
`ifdef CLKDIV_PHASE_ALIGN_EN
    logic              phase_sync = 1'b0;
`endif
    logic [NUM_CH-1:0] div_pending;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int exp_v;
    int q0[$];
    int q1[$];

    clock_divider_multi #(
        .CNT_W       (CNT_W),
        .NUM_CH      (NUM_CH),
        .DIV_DEFAULT (100)
    ) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
`ifdef CLKDIV_PHASE_ALIGN_EN
        .phase_sync  (phase_sync),
`endif
        .enable      (enable),
        .div_load    (div_load),
        .div_ch      (div_ch),
        .div_value   (div_value),
        .div_pending (div_pending),
        .clk_out     (clk_out),
        .tick        (tick)
    );

    always #5 clk_in = ~clk_in;

    // Cycle index: 0 right after the last reset edge, +1 per clock.
    always @(posedge clk_in) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Monitor: every observed tick must match the head of its channel queue.
    always @(negedge clk_in) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (tick[i] === 1'b1) begin
                n_tests++;
                if (i == 0) exp_v = (q0.size() == 0) ? -1 : q0.pop_front();
                else        exp_v = (q1.size() == 0) ? -1 : q1.pop_front();
                if (exp_v != cyc) begin
                    n_fail++;
                    $display("FAIL tick_ch%0d: tick seen at cycle %0d, required cycle %0d (-1 = no tick expected)",
                             i, cyc, exp_v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d, required finish before 200000 ns", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int ch, input int v);
        if (ch == 0) q0.push_back(v);
        else         q1.push_back(v);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk_in);
    endtask

    task automatic load(input logic [2:0] ch, input int v);
        div_load  = 1'b1;
        div_ch    = ch;
        div_value = CNT_W'(v);
        @(negedge clk_in);
        div_load  = 1'b0;
    endtask

    task automatic do_reset(input string name);
        reset_n  = 1'b0;
        enable   = 1'b1;
        div_load = 1'b0;
        repeat (2) @(negedge clk_in);
        chk({name, "_clk_out"}, 32'(clk_out), 32'h0);
        chk({name, "_tick"}, 32'(tick), 32'h0);
        chk({name, "_pending"}, 32'(div_pending), 32'h0);
        reset_n = 1'b1;
    endtask

    task automatic end_phase(input string name);
        chk({name, "_q0_left"}, 32'(q0.size()), 32'h0);
        chk({name, "_q1_left"}, 32'(q1.size()), 32'h0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        // Phase 1: default N=100 on both, then ch1 reloaded to 7 mid-period.
        do_reset("p1_rst");
        push(0, 50); push(0, 150); push(0, 250);
        push(1, 50); push(1, 150);
        for (int t = 203; t <= 259; t += 7) push(1, t);
        wait_cyc(49);  chk("p1_clk_49", 32'(clk_out), 32'h0);
        wait_cyc(50);  chk("p1_clk_50", 32'(clk_out), 32'h3);
        wait_cyc(99);  chk("p1_clk_99", 32'(clk_out), 32'h3);
        wait_cyc(100); chk("p1_clk_100", 32'(clk_out), 32'h0);
        wait_cyc(120); chk("p1_pend_120", 32'(div_pending), 32'h0);
        load(3'd1, 7);
        chk("p1_pend_121", 32'(div_pending), 32'h2);
        wait_cyc(199); chk("p1_pend_199", 32'(div_pending), 32'h2);
        wait_cyc(200); chk("p1_pend_200", 32'(div_pending), 32'h0);
        wait_cyc(202); chk("p1_clk_202", 32'(clk_out), 32'h0);
        wait_cyc(203); chk("p1_clk_203", 32'(clk_out), 32'h2);
        wait_cyc(206); chk("p1_clk_206", 32'(clk_out), 32'h2);
        wait_cyc(207); chk("p1_clk_207", 32'(clk_out), 32'h0);
        wait_cyc(255); load(3'd0, 10);
        wait_cyc(260);
        chk("p1_clk_260", 32'(clk_out), 32'h3);
        chk("p1_pend_260", 32'(div_pending), 32'h1);
        end_phase("p1");

        // Phase 2: last load wins, clamp of 0, out-of-range channel ignored.
        do_reset("p2_rst");
        push(0, 50); push(0, 110); push(0, 130);
        push(1, 50);
        for (int t = 101; t <= 139; t += 2) push(1, t);
        wait_cyc(10); load(3'd0, 10);
        wait_cyc(20); load(3'd0, 20);
        chk("p2_pend_21", 32'(div_pending), 32'h1);
        wait_cyc(30); load(3'd1, 0);
        chk("p2_pend_31", 32'(div_pending), 32'h3);
        wait_cyc(40); load(3'd5, 3);
        chk("p2_pend_41", 32'(div_pending), 32'h3);
        wait_cyc(99);  chk("p2_pend_99", 32'(div_pending), 32'h3);
        wait_cyc(100);
        chk("p2_pend_100", 32'(div_pending), 32'h0);
        chk("p2_clk_100", 32'(clk_out), 32'h0);
        wait_cyc(101); chk("p2_clk_101", 32'(clk_out), 32'h2);
        wait_cyc(109); chk("p2_clk_109", 32'(clk_out), 32'h2);
        wait_cyc(110); chk("p2_clk_110", 32'(clk_out), 32'h1);
        wait_cyc(140);
        end_phase("p2");

        // Phase 3: load on the wrap cycle is deferred one period; clamp of 1.
        do_reset("p3_rst");
        push(0, 50); push(0, 150);
        for (int t = 204; t <= 228; t += 8) push(0, t);
        push(1, 50);
        for (int t = 101; t <= 229; t += 2) push(1, t);
        wait_cyc(10); load(3'd1, 1);
        wait_cyc(99); chk("p3_pend_99", 32'(div_pending), 32'h2);
        load(3'd0, 8);
        chk("p3_pend_100", 32'(div_pending), 32'h1);
        wait_cyc(199); chk("p3_pend_199", 32'(div_pending), 32'h1);
        wait_cyc(200); chk("p3_pend_200", 32'(div_pending), 32'h0);
        wait_cyc(203); chk("p3_clk0_203", 32'(clk_out[0]), 32'h0);
        wait_cyc(204); chk("p3_clk0_204", 32'(clk_out[0]), 32'h1);
        wait_cyc(207); chk("p3_clk0_207", 32'(clk_out[0]), 32'h1);
        wait_cyc(208); chk("p3_clk0_208", 32'(clk_out[0]), 32'h0);
        wait_cyc(230);
        end_phase("p3");

        // Phase 4: 37-cycle freeze in the high phase, load captured while frozen.
        do_reset("p4_rst");
        push(0, 50); push(0, 187);
        push(1, 50);
        for (int t = 139; t <= 199; t += 4) push(1, t);
        wait_cyc(60); chk("p4_clk_60", 32'(clk_out), 32'h3);
        enable = 1'b0;
        wait_cyc(61); chk("p4_clk_61", 32'(clk_out), 32'h3);
        wait_cyc(70); load(3'd1, 4);
        chk("p4_pend_71", 32'(div_pending), 32'h2);
        wait_cyc(97); chk("p4_clk_97", 32'(clk_out), 32'h3);
        enable = 1'b1;
        wait_cyc(136);
        chk("p4_clk_136", 32'(clk_out), 32'h3);
        chk("p4_pend_136", 32'(div_pending), 32'h2);
        wait_cyc(137);
        chk("p4_clk_137", 32'(clk_out), 32'h0);
        chk("p4_pend_137", 32'(div_pending), 32'h0);
        wait_cyc(187); chk("p4_clk_187", 32'(clk_out), 32'h3);
        wait_cyc(200);
        end_phase("p4");

`ifdef CLKDIV_PHASE_ALIGN_EN
        // Phase 5: phase_sync restarts both channels and applies pending N.
        do_reset("p5_rst");
        push(0, 50); push(0, 103); push(0, 109); push(0, 115);
        push(0, 127); push(0, 139); push(0, 151);
        push(1, 50); push(1, 104); push(1, 113);
        push(1, 125); push(1, 134); push(1, 143); push(1, 152);
        wait_cyc(5); load(3'd0, 6); load(3'd1, 9);
        wait_cyc(119); load(3'd0, 12);
        chk("p5_pend_120", 32'(div_pending), 32'h1);
        phase_sync = 1'b1;
        @(negedge clk_in);
        phase_sync = 1'b0;
        chk("p5_clk_121", 32'(clk_out), 32'h0);
        chk("p5_pend_121", 32'(div_pending), 32'h0);
        wait_cyc(139); chk("p5_clk_139", 32'(clk_out), 32'h1);
        wait_cyc(145); chk("p5_clk_145", 32'(clk_out), 32'h2);
        wait_cyc(157); chk("p5_clk_157", 32'(clk_out), 32'h0);
        wait_cyc(158);
        end_phase("p5");
`endif

        do_reset("final_rst");
        repeat (3) @(negedge clk_in);
        end_phase("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
